// File: rtl/tt_pin_exerciser.sv
// Pin-level self-test engine for a TinyTapeout user project: LFSR stimulus out, MISR signature in.
// Define PINEX_OE_MASK_EN to mask dut_uio_out with dut_uio_oe before compaction.
module tt_pin_exerciser #(
  parameter logic [15:0] SEED = 16'h0001,
  parameter int unsigned LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_vec,
  output logic        busy,
  output logic        done,
  output logic [31:0] signature,
  output logic [15:0] vec_count,
  output logic [7:0]  dut_ui_in,
  output logic [7:0]  dut_uio_in,
  output logic        dut_ena,
  output logic        dut_rst_n,
  input  logic [7:0]  dut_uo_out,
  input  logic [7:0]  dut_uio_out,
  input  logic [7:0]  dut_uio_oe
);

  typedef enum logic [2:0] {StIdle, StPreRst, StRun, StDrain, StDone} state_e;

  localparam logic [15:0] SeedEff   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [2:0]  LatIdx    = 3'(LAT);
  localparam bit          HasDrain  = (LAT != 0);
  localparam logic [15:0] DrainInit = HasDrain ? 16'(LAT - 1) : 16'd0;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] n_q, n_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] sig_q, sig_d;
  logic [15:0] vcnt_q, vcnt_d;
  logic [6:0]  vld_q, vld_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  ui_q, ui_d;
  logic [7:0]  uio_q, uio_d;
  logic        ena_q, ena_d;
  logic        rstn_q, rstn_d;

  logic [7:0]  vld_all;
  logic [7:0]  uio_term;
  logic [31:0] word;

`ifdef PINEX_OE_MASK_EN
  assign uio_term = dut_uio_out & dut_uio_oe;
`else
  assign uio_term = dut_uio_out;
`endif

  assign word = {8'h00, dut_uio_oe, uio_term, dut_uo_out};

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] w);
    return ({s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0)) ^ w;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    lfsr_d  = lfsr_q;
    sig_d   = sig_q;
    vcnt_d  = vcnt_q;

    // Bit 0 marks a vector on the pins this cycle; bit LAT marks its response arriving.
    vld_all = {vld_q, state_q == StRun};
    vld_d   = vld_all[6:0];
    if (vld_all[LatIdx]) sig_d = misr_step(sig_q, word);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sig_d  = 32'hFFFFFFFF;
          vcnt_d = 16'd0;
          if (num_vec == 16'd0) begin
            state_d = StDone;
          end else begin
            n_d     = num_vec;
            lfsr_d  = SeedEff;
            cnt_d   = 16'd3;
            state_d = StPreRst;
          end
        end
      end
      StPreRst: begin
        if (cnt_q == 16'd0) begin
          state_d = StRun;
          cnt_d   = n_q - 16'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StRun: begin
        vcnt_d = vcnt_q + 16'd1;
        if (cnt_q == 16'd0) begin
          state_d = HasDrain ? StDrain : StDone;
          cnt_d   = DrainInit;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StDrain: begin
        if (cnt_q == 16'd0) state_d = StDone;
        else cnt_d = cnt_q - 16'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Pin outputs are decoded from the next state so they are flop outputs.
    busy_d = (state_d == StPreRst) || (state_d == StRun) || (state_d == StDrain);
    done_d = (state_d == StDone);
    ena_d  = busy_d;
    rstn_d = (state_d == StRun) || (state_d == StDrain);
    ui_d   = 8'h00;
    uio_d  = 8'h00;
    if (state_d == StRun) begin
      ui_d   = lfsr_q[7:0];
      uio_d  = lfsr_q[15:8];
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      n_q     <= 16'd0;
      lfsr_q  <= SeedEff;
      sig_q   <= 32'hFFFFFFFF;
      vcnt_q  <= 16'd0;
      vld_q   <= 7'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ui_q    <= 8'h00;
      uio_q   <= 8'h00;
      ena_q   <= 1'b0;
      rstn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      lfsr_q  <= lfsr_d;
      sig_q   <= sig_d;
      vcnt_q  <= vcnt_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ui_q    <= ui_d;
      uio_q   <= uio_d;
      ena_q   <= ena_d;
      rstn_q  <= rstn_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign signature  = sig_q;
  assign vec_count  = vcnt_q;
  assign dut_ui_in  = ui_q;
  assign dut_uio_in = uio_q;
  assign dut_ena    = ena_q;
  assign dut_rst_n  = rstn_q;

endmodule
